// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source edge-triggered interrupt controller with a small
// register interface (MASK, PENDING, VECTOR, SWSET).
// Source 0 has the highest priority. The CPU acknowledges with int_ack.
// The acknowledged source id is captured in VECTOR.
// Optional build macro IRQ_CTRL_SYNC_EN adds a two-flop synchroniser on
// src_in ahead of edge detection. Without it, src_in feeds edge detection directly.
module irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src_in,
  output logic       irq,
  input  logic       int_ack,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout
);

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_VEC   = 2'd2;
  localparam logic [1:0] ADDR_SWSET = 2'd3;

  logic [7:0] src_s;
  logic [7:0] src_q;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] vector;
  logic [1:0] arm_cnt;
  logic       armed;

  logic [7:0] live;
  logic [7:0] edges;
  logic [7:0] set_bits;
  logic [7:0] clr_bits;
  logic       ack_hit;
  logic [2:0] ack_id;
  logic [7:0] vector_n;
  logic [7:0] pending_n;
  logic [7:0] mask_n;
  logic [7:0] rd_data;

`ifdef IRQ_CTRL_SYNC_EN
  // Edge detection stays blocked until the synchroniser is full.
  // It also stays blocked until src_q has taken one real sample.
  localparam logic [1:0] ARM_CYCLES = 2'd3;

  logic [7:0] sync1;
  logic [7:0] sync2;

  // Two-flop synchroniser on the raw source lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  // Only the first post-reset edge is blocked.
  // On that edge src_q loads the live source level.
  localparam logic [1:0] ARM_CYCLES = 2'd1;

  assign src_s = src_in;
`endif

  assign armed = (arm_cnt == ARM_CYCLES);

  // Count post-reset edges until edge detection may be trusted.
  // NOTE: sequential state uses non-blocking assignments.
  //       All flops then update together on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // Next-state logic for PENDING, VECTOR and MASK, and the read-data mux.
  // NOTE: every signal gets a default at the top of the block.
  //       This keeps the block purely combinational (no latches).
  always_comb begin
    live     = pending & mask;
    edges    = armed ? (src_s & ~src_q) : 8'h00;
    set_bits = edges;
    clr_bits = 8'h00;
    ack_hit  = 1'b0;
    ack_id   = 3'd0;
    vector_n = vector;
    mask_n   = mask;
    rd_data  = 8'h00;

    if (reg_wr && reg_addr == ADDR_SWSET) set_bits = set_bits | reg_din;
    if (reg_wr && reg_addr == ADDR_PEND)  clr_bits = reg_din;
    if (reg_wr && reg_addr == ADDR_MASK)  mask_n   = reg_din;

    // Scan downward so the lowest-index live bit is the one that sticks.
    for (int i = 7; i >= 0; i--) begin
      if (live[i]) begin
        ack_hit = 1'b1;
        ack_id  = 3'(i);
      end
    end

    if (int_ack) begin
      if (ack_hit) begin
        vector_n         = {1'b1, 4'b0000, ack_id};
        clr_bits[ack_id] = 1'b1;
      end else begin
        vector_n = 8'h00;
      end
    end

    // Set is applied after clear, so a set wins over a clear of the same bit.
    pending_n = (pending & ~clr_bits) | set_bits;

    // Reads use the current (pre-write) register contents.
    case (reg_addr)
      ADDR_MASK: rd_data = mask;
      ADDR_PEND: rd_data = pending;
      ADDR_VEC:  rd_data = vector;
      default:   rd_data = 8'h00;
    endcase
  end

  // Controller state, registered irq and registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q    <= '0;
      mask     <= '0;
      pending  <= '0;
      vector   <= '0;
      irq      <= 1'b0;
      reg_dout <= '0;
    end else begin
      src_q    <= src_s;
      mask     <= mask_n;
      pending  <= pending_n;
      vector   <= vector_n;
      irq      <= |live;
      reg_dout <= reg_rd ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run.
// Results are compared against a behavioural model of the interrupt controller.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] src_in = 8'h00;
  logic       irq;
  logic       int_ack = 1'b0;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_din = 8'h00;
  logic [7:0] reg_dout;

  int checks = 0;
  int errors = 0;

  irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .src_in   (src_in),
    .irq      (irq),
    .int_ack  (int_ack),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [7:0] m_mask, m_pend, m_vec, m_dout;
  logic [7:0] m_seen;   // last source level seen by the edge detector
  logic [7:0] m_pipe [$];
  logic       m_irq;
  int         m_since;  // clock edges since reset released

  // Advance the model by one clock edge, using the inputs currently applied.
  task automatic model_edge();
    logic [7:0] level, rise, sets, clears, live, old_pend, old_mask, old_vec;
    int win;
    if (!rst) begin
      m_mask = 0; m_pend = 0; m_vec = 0; m_dout = 0; m_irq = 0;
      m_seen = 0; m_since = 0;
      m_pipe.delete();
      for (int i = 0; i < LAT; i++) m_pipe.push_back(8'h00);
      return;
    end
    m_pipe.push_back(src_in);
    level = m_pipe.pop_front();
    m_since++;
    // Rising edges only count once the first post-reset sample has been taken.
    rise = (m_since > LAT + 1) ? (level & ~m_seen) : 8'h00;
    m_seen = level;
    old_pend = m_pend; old_mask = m_mask; old_vec = m_vec;
    live = old_pend & old_mask;
    sets = rise;
    clears = 8'h00;
    if (reg_wr && reg_addr == 2'd3) sets = sets | reg_din;
    if (reg_wr && reg_addr == 2'd1) clears = reg_din;
    if (int_ack) begin
      win = -1;
      for (int i = 0; i < 8; i++) if (live[i] && win < 0) win = i;
      if (win >= 0) begin
        m_vec = 8'h80 + 8'(win);
        clears[win] = 1'b1;
      end else begin
        m_vec = 8'h00;
      end
    end
    m_pend = (old_pend & ~clears) | sets;
    if (reg_wr && reg_addr == 2'd0) m_mask = reg_din;
    m_irq = (live != 0);
    if (!reg_rd) m_dout = 8'h00;
    else if (reg_addr == 2'd0) m_dout = old_mask;
    else if (reg_addr == 2'd1) m_dout = old_pend;
    else if (reg_addr == 2'd2) m_dout = old_vec;
    else m_dout = 8'h00;
  endtask

  // Advance one clock edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    step();
    reg_wr = 1'b0; reg_din = 8'h00;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] d);
    reg_rd = 1'b1; reg_addr = a;
    step();
    reg_rd = 1'b0;
    d = reg_dout;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    // Heavy activity during reset must all be overridden.
    rst = 1'b0; src_in = 8'hFF; int_ack = 1'b1;
    reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 2'd0; reg_din = 8'hFF;
    step(); step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (reg_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", reg_dout); end
    src_in = 8'h00; int_ack = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_din = 8'h00;
    rst = 1'b1;
    repeat (LAT + 2) step();
    do_read(2'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_mask got=%h exp=00", d); end
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", d); end
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h exp=00", d); end
  endtask

  task automatic test_edge_latency();
    logic [7:0] d;
    src_in = 8'h00;
    do_reset();
    repeat (LAT + 2) step();
    do_write(2'd0, 8'hFF);
    src_in[3] = 1'b1;
    repeat (LAT) step();
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL edge_pending got=%h exp=08", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq got=%b exp=1", irq); end
  endtask

  task automatic test_ack();
    logic [7:0] d;
    do_write(2'd3, 8'h02);   // PENDING becomes 0x0A
    do_ack();
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL ack1_vector got=%h exp=81", d); end
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL ack1_vector_hold got=%h exp=81", d); end
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL ack1_pending got=%h exp=08", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ack1_irq got=%b exp=1", irq); end
    do_ack();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ack2_irq_same_edge got=%b exp=1", irq); end
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h83) begin errors++; $display("FAIL ack2_vector got=%h exp=83", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ack2_irq got=%b exp=0", irq); end
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ack2_pending got=%h exp=00", d); end
    do_read(2'd3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL swset_read got=%h exp=00", d); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    src_in = 8'h00;
    do_reset();
    repeat (LAT + 2) step();
    src_in[0] = 1'b1;
    repeat (LAT + 1) step();
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL mask_pending got=%h exp=01", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off got=%b exp=0", irq); end
    do_write(2'd0, 8'h01);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_write_edge got=%b exp=0", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on got=%b exp=1", irq); end
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    src_in = 8'h00;
    do_reset();
    repeat (LAT + 2) step();
    do_write(2'd0, 8'h04);
    do_write(2'd3, 8'h04);
    do_ack();
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h82) begin errors++; $display("FAIL race_pre_vector got=%h exp=82", d); end
    do_write(2'd0, 8'h00);
    src_in[2] = 1'b1;
    repeat (LAT) step();
    do_write(2'd1, 8'h04);   // W1C on the same edge the new edge is detected
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL race_pending got=%h exp=04", d); end
    do_ack();
    do_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL empty_ack_vector got=%h exp=00", d); end
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL empty_ack_pending got=%h exp=04", d); end
  endtask

  task automatic test_held_through_reset();
    logic [7:0] d;
    rst = 1'b0; src_in = 8'h20;
    step(); step();
    rst = 1'b1;
    repeat (LAT + 3) step();
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL held_pending got=%h exp=00", d); end
    src_in[5] = 1'b0;
    repeat (LAT + 2) step();
    src_in[5] = 1'b1;
    repeat (LAT + 1) step();
    do_read(2'd1, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL reedge_pending got=%h exp=20", d); end
    step();
    checks++;
    if (reg_dout !== 8'h00) begin errors++; $display("FAIL dout_one_cycle got=%h exp=00", reg_dout); end
  endtask

  task automatic test_random();
    src_in = 8'h00;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      src_in   = src_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rst      = ($urandom_range(0, 199) != 0);
      int_ack  = ($urandom_range(0, 5) == 0);
      reg_wr   = ($urandom_range(0, 3) == 0);
      reg_rd   = ($urandom_range(0, 2) == 0);
      reg_addr = 2'($urandom);
      reg_din  = 8'($urandom) & 8'($urandom);
      step();
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rand_irq cycle=%0d got=%b exp=%b", n, irq, m_irq);
      end
      checks++;
      if (reg_dout !== m_dout) begin
        errors++; $display("FAIL rand_dout cycle=%0d got=%h exp=%h", n, reg_dout, m_dout);
      end
    end
    rst = 1'b1; int_ack = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_ack();
    test_mask();
    test_set_wins();
    test_held_through_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 The block SHALL have: rst  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-003 The block SHALL have: src_in  input  8  interrupt source lines, rising-edge triggered; bit 0 is highest priority.
REQ-004 The block SHALL have: irq  output  1  registered interrupt request to the CPU controller.
REQ-005 The block SHALL have: int_ack  input  1  one-cycle pulse from the CPU controller while it is in the interrupt service state.
REQ-006 The block SHALL have: reg_wr  input  1  register write strobe.
REQ-007 The block SHALL have: reg_rd  input  1  register read strobe.
REQ-008 The block SHALL have: reg_addr  input  2  register select.
REQ-009 The block SHALL have: reg_din  input  8  write data.
REQ-010 The block SHALL have: reg_dout  output  8  registered read data; zero when not reading, for wired-OR bus use.

Function
REQ-011 Register map SHALL be: 0 MASK (RW, 1 = source enabled); 1 PENDING (R, write-1-to-clear); 2 VECTOR (R: bit7 valid, bits2:0 captured source id, bits6:3 zero); 3 SWSET (W, write-1 sets PENDING bits; reads 0).
REQ-012 Edge detect SHALL use a one-flop previous sample src_q; edge[i] = src_s[i] & ~src_q[i], where src_s is src_in, or its synchronised copy per REQ-027.
REQ-013 A detected edge SHALL set PENDING[i] at the same clock edge on which the edge is detected, regardless of MASK.
REQ-014 irq SHALL be registered as |(PENDING & MASK), giving 1 clock of latency from PENDING/MASK change to irq.
REQ-015 Without synchronisation, src_in rising before edge k SHALL yield PENDING[i]=1 after edge k and irq=1 after edge k+1.
REQ-016 On int_ack, VECTOR SHALL capture the lowest-index set bit of PENDING & MASK with valid=1, and that PENDING bit SHALL be cleared at the same edge.
REQ-017 If int_ack arrives with PENDING & MASK == 0, VECTOR SHALL become 0x00 (valid=0), and PENDING SHALL be unchanged.
REQ-018 VECTOR SHALL hold its value until the next int_ack; a read does not clear it.
REQ-019 Simultaneous set and clear of the same PENDING bit SHALL resolve as set wins. Clear sources are a W1C write or int_ack; set sources are an edge or SWSET.
REQ-020 A reg_rd SHALL drive reg_dout with the addressed register one clock later for exactly one cycle; otherwise reg_dout SHALL be 0.
REQ-021 A simultaneous reg_wr and reg_rd to the same address SHALL return the pre-write value.
REQ-022 A write to MASK SHALL take effect on irq with the REQ-014 latency; masked pending bits SHALL be retained.
REQ-023 A source held high SHALL produce only one PENDING set per low-to-high transition.

Reset
REQ-024 While rst=0 at a clock edge, MASK, PENDING, VECTOR, src_q, the synchroniser flops, irq and reg_dout SHALL all become 0.
REQ-025 Reset SHALL override every concurrent event, including an edge, int_ack, reg_wr or reg_rd in the same cycle.
REQ-026 A source already high when reset deasserts SHALL NOT generate an edge until it goes low and high again, because src_q is loaded from src_s on the first post-reset edge.

Configuration
REQ-027 With macro IRQ_CTRL_SYNC_EN defined, src_in SHALL pass through a two-flop synchroniser before edge detection, adding 2 clocks to the REQ-015 latency (PENDING after edge k+2, irq after k+3).
REQ-028 Without IRQ_CTRL_SYNC_EN, src_in SHALL feed edge detection directly and the synchroniser flops SHALL be absent.

Verification
REQ-029 Reset, write MASK=0xFF, raise src_in[3] -> PENDING=0x08 one edge later, irq=1 the next edge; with IRQ_CTRL_SYNC_EN each occurs 2 clocks later.
REQ-030 PENDING=0x0A, MASK=0xFF, pulse int_ack -> VECTOR=0x81, PENDING=0x08, irq stays 1; a second int_ack -> VECTOR=0x83, PENDING=0x00, irq=0 one clock later.
REQ-031 MASK=0x00, raise src_in[0] -> PENDING=0x01 and irq=0; write MASK=0x01 -> irq=1 one clock after the write.
REQ-032 W1C write of 0x04 to PENDING in the same cycle as a new src_in[2] edge -> PENDING[2]=1; int_ack with PENDING & MASK == 0 -> VECTOR=0x00.
REQ-033 Hold src_in[5] high through deassertion of rst -> no PENDING; then drop and raise src_in[5] -> PENDING=0x20; reg_rd at address 1 -> reg_dout=0x20 for one cycle, then 0.
